// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared types and helpers for the parallel-to-serial transmit path.
//   ser_state_t : serializer FSM states (IDLE, SHIFT, DONE)
//   cnt_w()     : width of the bit counter for a given word width
//   PAR_EVEN / PAR_ODD : encodings of the par_type input
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Counter width able to hold 0..data_w.
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage : ser_pkg

// File: rtl/par_serializer.sv
// ---------------------------------------------------------------------------
// par_serializer
// Parametrised parallel-to-serial converter. A word is accepted while the
// serializer is idle (or in its DONE cycle, for back-to-back words) and then
// shifted out one bit per clock in which ser_en is high, LSB- or MSB-first.
// A parity bit of the accepted word is registered at latch time.
//
// Parameters:
//   DATA_W     : word width, 2..32
//   IDLE_LEVEL : level driven on ser_data while idle
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   data_valid : p_data valid (sampled only in IDLE or DONE)
//   p_data     : parallel word
//   msb_first  : 1 = send bit DATA_W-1 first, sampled with p_data
//   par_type   : 0 = even parity, 1 = odd parity, sampled with p_data
//   ser_en     : shift enable; low in SHIFT freezes everything
//   ser_data   : serial bit (registered)
//   ser_done   : high during the cycle the last bit is on ser_data
//   busy       : high while a word is in flight (SHIFT or DONE)
//   par_bit    : registered parity of the latched word
// ---------------------------------------------------------------------------
module par_serializer
    import ser_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] p_data,
    input  logic              msb_first,
    input  logic              par_type,
    input  logic              ser_en,
    output logic              ser_data,
    output logic              ser_done,
    output logic              busy,
    output logic              par_bit
);

    localparam int CW = cnt_w(DATA_W);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

    ser_state_t        state_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic              order_q;
    logic              ser_data_q;
    logic              par_q;

    // Combinational helpers feeding the registers.
    logic              accept;
    logic              par_d;
    logic [CW-1:0]     bit_idx;
    logic [DATA_W-1:0] shifted;
    logic              bit_d;

    // A new word is taken only when nothing is being shifted.
    assign accept = data_valid && ((state_q == IDLE) || (state_q == DONE));

    assign par_d = (^p_data) ^ (par_type == PAR_ODD);

    // Index of the bit to drive next; a right shift avoids an over-wide
    // part-select index when CW exceeds clog2(DATA_W).
    assign bit_idx = order_q ? (LAST_IDX - cnt_q) : cnt_q;
    assign shifted = shreg_q >> bit_idx;
    assign bit_d   = shifted[0];

    // NOTE: every register, including the shift register, is in the async
    // reset list so a mid-word reset discards the word completely; all state
    // updates use non-blocking assignments so the later accept branch can
    // cleanly override the per-state defaults within the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            order_q    <= 1'b0;
            ser_data_q <= IDLE_LEVEL;
            par_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ser_data_q <= IDLE_LEVEL;
                end
                SHIFT: begin
                    if (ser_en) begin
                        ser_data_q <= bit_d;
                        cnt_q      <= cnt_q + CW'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // ser_en is ignored here; without a new word, return
                    // to idle. With a new word, ser_data keeps the last bit.
                    state_q    <= IDLE;
                    ser_data_q <= IDLE_LEVEL;
                    if (data_valid) begin
                        ser_data_q <= ser_data_q;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ser_data_q <= IDLE_LEVEL;
                end
            endcase

            if (accept) begin
                shreg_q <= p_data;
                order_q <= msb_first;
                par_q   <= par_d;
                cnt_q   <= '0;
                state_q <= SHIFT;
            end
        end
    end

    assign ser_data = ser_data_q;
    assign par_bit  = par_q;
    assign ser_done = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule : par_serializer

// File: tb/tb_par_serializer.sv
// ---------------------------------------------------------------------------
// tb_par_serializer
// Two serializer instances (8-bit, IDLE_LEVEL 0; 12-bit, IDLE_LEVEL 1).
// Each cycle the driver advances a word-level reference model (bit sequence
// plus bits-remaining count) and queues the expected outputs for the next
// edge; a monitor per instance pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_par_serializer;

    localparam int W0 = 8;
    localparam int W1 = 12;

    typedef struct packed {
        logic sd;
        logic done;
        logic busy;
        logic par;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        dv  [2];
    logic [31:0] pd  [2];
    logic        msb [2];
    logic        pt  [2];
    logic        en  [2];

    logic sd0, dn0, bz0, pb0;
    logic sd1, dn1, bz1, pb1;
    obs_t obs0, obs1;
    assign obs0 = {sd0, dn0, bz0, pb0};
    assign obs1 = {sd1, dn1, bz1, pb1};

    par_serializer #(.DATA_W(W0), .IDLE_LEVEL(1'b0)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .data_valid (dv[0]),
        .p_data     (pd[0][W0-1:0]),
        .msb_first  (msb[0]),
        .par_type   (pt[0]),
        .ser_en     (en[0]),
        .ser_data   (sd0),
        .ser_done   (dn0),
        .busy       (bz0),
        .par_bit    (pb0)
    );

    par_serializer #(.DATA_W(W1), .IDLE_LEVEL(1'b1)) u_dut12 (
        .clk        (clk),
        .rst        (rst),
        .data_valid (dv[1]),
        .p_data     (pd[1][W1-1:0]),
        .msb_first  (msb[1]),
        .par_type   (pt[1]),
        .ser_en     (en[1]),
        .ser_data   (sd1),
        .ser_done   (dn1),
        .busy       (bz1),
        .par_bit    (pb1)
    );

    // ---------------- reference model ----------------
    int          wd [2];
    logic        il [2];
    logic [31:0] m_seq  [2];   // bits in transmission order, index 0 first
    int          m_left [2];   // bits still to be sent
    bit          m_busy [2];   // a word is in flight (including its done cycle)
    logic        m_sd   [2];
    logic        m_par  [2];

    obs_t exp_q0[$];
    obs_t exp_q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got sd,done,busy,par=%b required %b",
                      name, $time, act, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_seq[d]  = '0;
            m_left[d] = 0;
            m_busy[d] = 1'b0;
            m_sd[d]   = il[d];
            m_par[d]  = 1'b0;
        end
    endtask

    task automatic model_load(input int d);
        logic [31:0] mask;
        mask = (32'h1 << wd[d]) - 32'h1;
        m_seq[d] = '0;
        for (int i = 0; i < wd[d]; i++)
            m_seq[d][i] = msb[d] ? pd[d][wd[d]-1-i] : pd[d][i];
        m_left[d] = wd[d];
        m_busy[d] = 1'b1;
        m_par[d]  = (^(pd[d] & mask)) ^ pt[d];
    endtask

    // Effect of one rising edge given the current inputs.
    task automatic model_step(input int d);
        if (!m_busy[d]) begin
            if (dv[d]) model_load(d);
        end else if (m_left[d] == 0) begin
            if (dv[d]) model_load(d);
            else begin
                m_busy[d] = 1'b0;
                m_sd[d]   = il[d];
            end
        end else if (en[d]) begin
            m_sd[d]   = m_seq[d][wd[d] - m_left[d]];
            m_left[d] = m_left[d] - 1;
        end
    endtask

    function automatic obs_t model_obs(input int d);
        obs_t o;
        o.sd   = m_sd[d];
        o.done = m_busy[d] && (m_left[d] == 0);
        o.busy = m_busy[d];
        o.par  = m_par[d];
        return o;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (exp_q0.size() > 0) check("dut8", obs0, exp_q0.pop_front());
        if (exp_q1.size() > 0) check("dut12", obs1, exp_q1.pop_front());
    end

    // ---------------- driver helpers ----------------
    // Called 2 time units after a falling edge; covers the next rising edge.
    task automatic tick();
        model_step(0);
        exp_q0.push_back(model_obs(0));
        model_step(1);
        exp_q1.push_back(model_obs(1));
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] p,
                         input logic m, input logic t, input logic e);
        dv[d]  = v;
        pd[d]  = p;
        msb[d] = m;
        pt[d]  = t;
        en[d]  = e;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        exp_q0.delete();
        exp_q1.delete();
        check({tag, "_dut8"}, obs0, model_obs(0));
        check({tag, "_dut12"}, obs1, model_obs(1));
        #1;
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wd[0] = W0; wd[1] = W1;
        il[0] = 1'b0; il[1] = 1'b1;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("reset_dut8", obs0, model_obs(0));
        check("reset_dut12", obs1, model_obs(1));
        @(negedge clk);
        #2;
        rst = 1'b1;

        // 8'hA5 LSB-first, even parity
        drive(0, 1'b1, 32'hA5, 1'b0, 1'b0, 1'b1); tick();
        dv[0] = 1'b0; repeat (10) tick();

        // 8'hA5 MSB-first, odd parity
        drive(0, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1); tick();
        dv[0] = 1'b0; repeat (10) tick();

        // 8'h3C with a 3-cycle stall after bit 2
        drive(0, 1'b1, 32'h3C, 1'b0, 1'b0, 1'b1); tick();
        dv[0] = 1'b0; repeat (3) tick();
        en[0] = 1'b0; repeat (3) tick();
        en[0] = 1'b1; repeat (10) tick();

        // Back-to-back: 8'hFF then 8'h00 offered in the DONE cycle
        drive(0, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b1); tick();
        dv[0] = 1'b0; repeat (8) tick();
        drive(0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1); repeat (11) tick();

        // data_valid with 8'h55 during SHIFT of 8'h0F is ignored
        drive(0, 1'b1, 32'h0F, 1'b0, 1'b0, 1'b1); tick();
        dv[0] = 1'b0; repeat (3) tick();
        drive(0, 1'b1, 32'h55, 1'b1, 1'b1, 1'b1); tick();
        dv[0] = 1'b0; repeat (8) tick();

        // 12-bit: 12'hABC, reset after bit 5, then 12'h001
        drive(1, 1'b1, 32'hABC, 1'b0, 1'b0, 1'b1); tick();
        dv[1] = 1'b0; repeat (6) tick();
        do_reset("areset_mid_word");
        drive(1, 1'b1, 32'h001, 1'b0, 1'b0, 1'b1); tick();
        dv[1] = 1'b0; repeat (14) tick();

        // Randomised traffic on both instances, one reset in the middle
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++)
                drive(d, ($urandom_range(0, 3) == 0), $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0));
            if (i == 300) do_reset("areset_random");
            tick();
        end

        idle_inputs();
        en[0] = 1'b1; en[1] = 1'b1;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_par_serializer
